// File: rtl/serial_adder_seq.sv
// Bit-serial adder: consumes LSB-first operand bit pairs, one full add per
// accepted cycle, and presents the WIDTH-bit sum plus carry-out on a valid/ready port.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_bit,
    input  logic             b_bit,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sum_sr, sum_sr_nxt;
    logic             carry, carry_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       fa;

    // Half-adder cell: {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full add from two half-adder cells; the two carries can never both be set.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        logic [1:0] h0;
        logic [1:0] h1;
        h0 = half_add(x, y);
        h1 = half_add(h0[0], c);
        return {h0[1] | h1[1], h1[0]};
    endfunction

    assign fa = full_add(a_bit, b_bit, carry);

    always_comb begin
        state_nxt  = state;
        sum_sr_nxt = sum_sr;
        carry_nxt  = carry;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    sum_sr_nxt = '0;
                    carry_nxt  = 1'b0;
                    cnt_nxt    = '0;
                    state_nxt  = ACCUM;
                end
            end
            ACCUM: begin
                // New sum bit enters the MSB; after WIDTH shifts bit 0 holds the LSB.
                if (bit_valid) begin
                    sum_sr_nxt = {fa[0], sum_sr[WIDTH-1:1]};
                    carry_nxt  = fa[1];
                    cnt_nxt    = cnt + CNT_W'(1);
                    if (cnt == LAST_IDX) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            sum_sr <= sum_sr_nxt;
            carry  <= carry_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // The carry register holds the final carry-out while the result waits in HOLD.
    assign sum_out   = sum_sr;
    assign cout      = carry;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule
